// File: rtl/bmstu_task_4_spi_master.sv
// SPI mode-0 initiator: turns one valid/ready write request into one CS-low frame of
// 64 SCK pulses carrying {cmd, addr, data} LSB-first.
module bmstu_task_4_spi_master #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_cmd_i,
  input  logic [23:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        spi_sck_o,
  output logic        spi_cs_o,
  output logic        spi_copi_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is taken on a rising clk edge where req_valid_i && req_ready_o;
  // req_ready_o depends only on the FSM state, never on req_valid_i.

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [6:0]    bit_cnt, bit_n;
  logic [63:0]   shreg, sh_n;
  logic          sck, sck_n;
  logic          cs, cs_n;
  logic          done, done_n;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      cs      <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      gap_cnt <= gap_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      sck     <= sck_n;
      cs      <= cs_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    gap_n   = gap_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    sck_n   = sck;
    cs_n    = cs;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cs_n  = 1'b1;
        sck_n = 1'b0;
        sh_n  = '0;
        if (req_valid_i) begin
          state_n = SETUP;
          sh_n    = {req_cmd_i, req_addr_i, req_data_i};
          cs_n    = 1'b0;
          div_n   = '0;
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_n = SHIFT;
          div_n   = '0;
          bit_n   = '0;
          sck_n   = 1'b1;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n = '0;
          if (sck) begin
            // Falling edge: the next bit moves onto COPI, away from the slave's sample edge.
            sck_n = 1'b0;
            sh_n  = {1'b0, shreg[63:1]};
          end else if (bit_cnt == 7'd63) begin
            state_n = GAP;
            cs_n    = 1'b1;
            sh_n    = '0;
            done_n  = 1'b1;
            gap_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
            sck_n = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // COPI is the shift register's LSB, so it is a flop output and reads 0 when idle.
  assign spi_copi_o  = shreg[0];
  assign spi_sck_o   = sck;
  assign spi_cs_o    = cs;
  assign done_o      = done;
  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_bmstu_task_4_spi_master.sv
// Bench for the SPI write-frame initiator: a slave model reassembles each frame and a
// scoreboard compares it, with frame timing, against the queued expectation.
module tb_bmstu_task_4_spi_master;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT A: CLK_DIV=2, GAP_CYCLES=4 ----------------
  logic        valid = 1'b0;
  logic [7:0]  cmd = '0;
  logic [23:0] addr = '0;
  logic [31:0] data = '0;
  logic        ready, sck, cs, copi, busy, done;
  logic [1:0]  dbg;

  bmstu_task_4_spi_master #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut (
    .clk(clk), .arst(arst), .req_valid_i(valid), .req_ready_o(ready),
    .req_cmd_i(cmd), .req_addr_i(addr), .req_data_i(data),
    .spi_sck_o(sck), .spi_cs_o(cs), .spi_copi_o(copi),
    .busy_o(busy), .done_o(done), .dbg_state_o(dbg)
  );

  // ---------------- DUT B: CLK_DIV=1, GAP_CYCLES=1 ----------------
  logic        b_valid = 1'b0;
  logic [7:0]  b_cmd = '0;
  logic [23:0] b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready, b_sck, b_cs, b_copi, b_busy, b_done;
  logic [1:0]  b_dbg;

  bmstu_task_4_spi_master #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut_b (
    .clk(clk), .arst(arst), .req_valid_i(b_valid), .req_ready_o(b_ready),
    .req_cmd_i(b_cmd), .req_addr_i(b_addr), .req_data_i(b_data),
    .spi_sck_o(b_sck), .spi_cs_o(b_cs), .spi_copi_o(b_copi),
    .busy_o(b_busy), .done_o(b_done), .dbg_state_o(b_dbg)
  );

  logic [63:0] exp_q[$];
  logic [63:0] b_exp_q[$];
  bit b2b = 1'b0;
  int edges = 0;
  int stray = 0;
  int ready_viol = 0;
  int b_stray = 0;

  // ---------------- monitor A ----------------
  initial begin
    logic [63:0] rx;
    logic [63:0] e;
    int cs_low, hs_cyc;
    bit prev_sck, have_last;
    rx = '0; cs_low = 0; hs_cyc = 0; prev_sck = 0; have_last = 0;
    forever begin
      @(negedge clk);
      if (arst) begin
        edges = 0; cs_low = 0; prev_sck = 0; have_last = 0;
      end else begin
        if (!cs) cs_low++;
        if (sck && !prev_sck) begin
          if (cs) stray++;
          else begin
            if (edges < 64) rx[edges[5:0]] = copi;
            edges++;
          end
        end
        prev_sck = sck;
        if (!cs && ready) ready_viol++;
        if (busy === ready) ready_viol++;
        if (done) begin
          if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("frame", rx, e);
            check("sck_edges", 64'(edges), 64'd64);
            check("cs_low_cycles", 64'(cs_low), 64'd258);
            check("hs_to_done", 64'(cyc - hs_cyc), 64'd259);
            check("cs_high_at_done", {63'd0, cs}, 64'd1);
          end
          edges = 0; cs_low = 0;
        end
        if (valid && ready) begin
          if (b2b && have_last) check("hs_spacing", 64'(cyc - hs_cyc), 64'd263);
          have_last = b2b;
          hs_cyc = cyc;
        end
      end
    end
  end

  // ---------------- monitor B ----------------
  initial begin
    logic [63:0] rx;
    logic [63:0] e;
    int cs_low, hs_cyc, b_edges;
    bit prev_sck, have_last;
    rx = '0; cs_low = 0; hs_cyc = 0; b_edges = 0; prev_sck = 0; have_last = 0;
    forever begin
      @(negedge clk);
      if (arst) begin
        b_edges = 0; cs_low = 0; prev_sck = 0; have_last = 0;
      end else begin
        if (!b_cs) cs_low++;
        if (b_sck && !prev_sck) begin
          if (b_cs) b_stray++;
          else begin
            if (b_edges < 64) rx[b_edges[5:0]] = b_copi;
            b_edges++;
          end
        end
        prev_sck = b_sck;
        if (b_done) begin
          if (b_exp_q.size() == 0) check("b_unexpected_done", 64'd1, 64'd0);
          else begin
            e = b_exp_q.pop_front();
            check("b_frame", rx, e);
            check("b_sck_edges", 64'(b_edges), 64'd64);
            check("b_cs_low_cycles", 64'(cs_low), 64'd129);
          end
          b_edges = 0; cs_low = 0;
        end
        if (b_valid && b_ready) begin
          if (have_last) check("b_hs_spacing", 64'(cyc - hs_cyc), 64'd131);
          have_last = 1'b1;
          hs_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    @(negedge clk);
    while (!ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    ok = ready;
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (busy || exp_q.size() != 0) check("idle_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                      input logic [63:0] expf, input bit scramble);
    bit ok;
    valid = 1'b1; cmd = c; addr = a; data = d;
    wait_ready(ok);
    if (ok) exp_q.push_back(expf);
    @(posedge clk); #1;
    valid = 1'b0;
    if (scramble) begin
      repeat (280) begin
        cmd = 8'($urandom); addr = 24'($urandom); data = $urandom;
        @(posedge clk); #1;
      end
    end
    wait_idle();
  endtask

  function automatic logic [63:0] vec(input logic [7:0] j);
    return {j, j, ~j, j, ~j, j, ~j, j};
  endfunction

  task automatic b2b_run();
    logic [7:0] js[4];
    bit ok;
    js[0] = 8'h00; js[1] = 8'h01; js[2] = 8'h3C; js[3] = 8'hFF;
    b2b = 1'b1;
    valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmd = js[k]; addr = {js[k], ~js[k], js[k]}; data = {~js[k], js[k], ~js[k], js[k]};
      wait_ready(ok);
      if (ok) exp_q.push_back(vec(js[k]));
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_idle();
    b2b = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    {63'd0, cs},    64'd1);
    check({tag, "_sck"},   {63'd0, sck},   64'd0);
    check({tag, "_copi"},  {63'd0, copi},  64'd0);
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_busy"},  {63'd0, busy},  64'd0);
    check({tag, "_done"},  {63'd0, done},  64'd0);
    check({tag, "_state"}, {62'd0, dbg},   64'd0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int k;
    bit ok;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("b_reset_cs", {63'd0, b_cs}, 64'd1);
    check("b_reset_ready", {63'd0, b_ready}, 64'd1);
    arst = 1'b0;
    @(posedge clk); #1;

    send(8'hA5, 24'hA55AA5, 32'h5AA55AA5, 64'hA5A55AA55AA55AA5, 1'b0);
    send(8'h12, 24'h345678, 32'h9ABCDEF0, 64'h123456789ABCDEF0, 1'b1);
    b2b_run();

    // abort mid-frame at bit 30
    valid = 1'b1; cmd = 8'hC3; addr = 24'h0F0F0F; data = 32'hDEADBEEF;
    wait_ready(ok);
    if (ok) exp_q.push_back(64'hC30F0F0FDEADBEEF);
    @(posedge clk); #1;
    valid = 1'b0;
    k = 0;
    while (edges < 31 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check("reach_bit30", 64'(edges), 64'd31);
    #2 arst = 1'b1;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;
    send(8'h5E, 24'h00FF00, 32'h80000001, 64'h5E00FF0080000001, 1'b0);

    // DUT B: continuous valid, three frames
    b_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      b_cmd = 8'h81 + 8'(n); b_addr = 24'h13579B; b_data = 32'h2468ACE0 + 32'(n);
      k = 0;
      @(negedge clk);
      while (!b_ready && k < 1000) begin
        @(negedge clk);
        k++;
      end
      if (b_ready) b_exp_q.push_back({b_cmd, b_addr, b_data});
      else check("b_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    k = 0;
    while ((b_busy || b_exp_q.size() != 0) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("sck_while_cs_high", 64'(stray), 64'd0);
    check("b_sck_while_cs_high", 64'(b_stray), 64'd0);
    check("ready_or_busy_during_frame", 64'(ready_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
